tape_device: RTL and testbench
==============================

# tape_device

Behavioural paper-tape reader/punch that sits directly outside the SoC top, on the device side of its 5-bit character handshakes. It buffers characters streamed in by the host (or testbench) and feeds them to the core's input handshake with a programmable mechanical reader delay. It also captures characters punched by the core's output handshake into a buffer drained by the host. Two independent FSMs plus two FIFOs; used both in simulation and on the board behind a host link.

## Interface
- IN_DEPTH, 16, input FIFO depth in characters (power of two, ≥2)
- OUT_DEPTH, 16, output FIFO depth in characters (power of two, ≥2)
- READ_DELAY, 4, extra cycles between reader request and character delivery (0 allowed)
- CNT_W, 16, width of character counters
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- host_in_valid / host_in_ready  in / out  1 / 1  host→reader stream handshake
- host_in_data  in  5  character to load on tape
- tape_flush  in  1  pulse: discard all unread tape characters
- dev_input_rdy  in  1  core requests a character (level)
- dev_input_val  out  1  one-cycle character-valid pulse to core
- dev_input_data  out  5  character, stable from the val cycle until next delivery
- dev_output_rdy  in  1  core presents a punch character (level)
- dev_output_data  in  5  punch character
- dev_output_ack  out  1  one-cycle punch-accepted pulse to core
- host_out_valid / host_out_ready  out / in  1 / 1  punch→host stream handshake
- host_out_data  out  5  oldest punched character
- in_count / out_count  out  CNT_W  characters delivered to / captured from core, wrapping

## Operation
- Host sides: host_in_ready = input FIFO not full; push on valid&&ready. host_out_valid = output FIFO not empty; pop on valid&&ready; host_out_data is FIFO head (first-word fall-through).
- Reader FSM RD_IDLE, RD_WAIT, RD_PULSE, RD_DONE:
  - RD_IDLE: dev_input_rdy && FIFO non-empty → RD_WAIT, delay counter ← READ_DELAY.
  - RD_WAIT: rdy low → RD_IDLE (abort, nothing popped); else counter==0 → RD_PULSE, dev_input_data ← FIFO head; else counter−1.
  - RD_PULSE: dev_input_val=1, FIFO pop, in_count+1 → RD_DONE.
  - RD_DONE: wait for dev_input_rdy low → RD_IDLE (one delivery per rdy assertion).
- Punch FSM PN_IDLE, PN_ACK, PN_DONE:
  - PN_IDLE: dev_output_rdy && output FIFO not full → push dev_output_data, out_count+1 → PN_ACK. FIFO full: stay, ack withheld (core stalls).
  - PN_ACK: dev_output_ack=1 → PN_DONE.
  - PN_DONE: wait for dev_output_rdy low → PN_IDLE.
- tape_flush: input FIFO emptied next cycle; wins over a simultaneous host push (push dropped, though host_in_ready may show 1). In RD_WAIT → RD_IDLE. In RD_PULSE the already-latched character is still delivered, and the FIFO ends empty.
- Counters wrap 2^CNT_W−1 → 0 silently.

## Timing
- Reset: both FSMs idle, FIFOs empty, dev_input_val=0, dev_input_data=0, dev_output_ack=0, host_out_valid=0, host_in_ready=1, counters 0.
- Reset mid-handshake aborts immediately; a pending val/ack pulse is not emitted.
- dev_input_val asserts exactly READ_DELAY+2 cycles after the first cycle rdy is sampled high in RD_IDLE with non-empty FIFO.
- dev_output_ack asserts 2 cycles after the first cycle rdy is sampled high in PN_IDLE with space.
- Host push-to-readable latency: 1 cycle. Output FIFO: push and pop in the same cycle allowed when non-empty.
- All outputs registered or decoded from state registers; no combinational path from dev_* inputs to outputs.

## Structure
- Shared package: FSM state encodings for reader and punch, character width constant CHAR_W=5.
- One sub-module: sync_fifo (params DEPTH, WIDTH; FWFT; push/pop/flush, full/empty), instantiated twice.

## Test plan
- READ_DELAY=4, load 0x11, hold rdy → val pulse at cycle 6, data=0x11, in_count=1; no second pulse while rdy stays high.
- Load 0x03,0x1F; two rdy assertions → 0x03 then 0x1F in order; third rdy with empty FIFO → no val, FSM stays RD_IDLE.
- rdy dropped in RD_WAIT → no val, no pop; next rdy delivers the same character.
- Core punches 0x0A,0x15 with host_out_ready=0, OUT_DEPTH=2 → two acks; third punch stalls (no ack) until host pops one, then acks; host reads 0x0A,0x15,… in order.
- tape_flush with 5 queued and simultaneous host push → FIFO empty, host_in_ready=1, rdy yields no val.
- Reset asserted during RD_WAIT and PN_ACK → no val/ack, all outputs at reset values next cycle; counters wrap test with CNT_W=2 (4 deliveries → in_count=0).

Source files
------------

// File: rtl/tape_device_pkg.sv
// tape_device_pkg: character width and reader/punch FSM encodings shared by the tape device
package tape_device_pkg;
  localparam int CHAR_W = 5;
  typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_PULSE, RD_DONE} rd_state_t;
  typedef enum logic [1:0] {PN_IDLE, PN_ACK, PN_DONE} pn_state_t;
endpackage

// File: rtl/tape_device_sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with flush; flush beats a same-cycle push or pop
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic w_push, w_pop;
  assign o_empty = r_wptr == r_rptr;
  assign o_full = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push = i_push && !o_full && !i_flush;
  assign w_pop = i_pop && !o_empty && !i_flush;
  assign o_dout = r_mem[r_rptr[AW-1:0]];
  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (w_push) r_mem[r_wptr[AW-1:0]] <= i_din;
endmodule

// File: rtl/tape_device.sv
// tape_device: paper-tape reader/punch model with a delayed reader handshake and a buffered punch
module tape_device
  import tape_device_pkg::*;
#(
  parameter int IN_DEPTH   = 16,
  parameter int OUT_DEPTH  = 16,
  parameter int READ_DELAY = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_in_valid,
  output logic              host_in_ready,
  input  logic [CHAR_W-1:0] host_in_data,
  input  logic              tape_flush,
  input  logic              dev_input_rdy,
  output logic              dev_input_val,
  output logic [CHAR_W-1:0] dev_input_data,
  input  logic              dev_output_rdy,
  input  logic [CHAR_W-1:0] dev_output_data,
  output logic              dev_output_ack,
  output logic              host_out_valid,
  input  logic              host_out_ready,
  output logic [CHAR_W-1:0] host_out_data,
  output logic [CNT_W-1:0]  in_count,
  output logic [CNT_W-1:0]  out_count
);
  localparam int DW = (READ_DELAY > 0) ? $clog2(READ_DELAY + 1) : 1;
  rd_state_t r_rd;
  pn_state_t r_pn;
  logic [DW-1:0] r_dly;
  logic [CHAR_W-1:0] r_in_data, w_in_head;
  logic [CNT_W-1:0] r_in_count, r_out_count;
  logic w_in_full, w_in_empty, w_out_full, w_out_empty, w_pn_push;
  sync_fifo #(.DEPTH(IN_DEPTH), .WIDTH(CHAR_W)) u_in_fifo (
    .clk(clk), .reset(reset), .i_push(host_in_valid), .i_pop(r_rd == RD_PULSE),
    .i_flush(tape_flush), .i_din(host_in_data), .o_dout(w_in_head),
    .o_full(w_in_full), .o_empty(w_in_empty)
  );
  sync_fifo #(.DEPTH(OUT_DEPTH), .WIDTH(CHAR_W)) u_out_fifo (
    .clk(clk), .reset(reset), .i_push(w_pn_push), .i_pop(host_out_ready),
    .i_flush(1'b0), .i_din(dev_output_data), .o_dout(host_out_data),
    .o_full(w_out_full), .o_empty(w_out_empty)
  );
  // A flush aborts a pending read, so the character latched here always exists
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd <= RD_IDLE;
      r_dly <= '0;
      r_in_data <= '0;
      r_in_count <= '0;
    end else begin
      case (r_rd)
        RD_IDLE: if (dev_input_rdy && !w_in_empty && !tape_flush) begin
          r_rd <= RD_WAIT;
          r_dly <= DW'(READ_DELAY);
        end
        RD_WAIT: if (!dev_input_rdy || tape_flush) r_rd <= RD_IDLE;
        else if (r_dly == '0) begin
          r_rd <= RD_PULSE;
          r_in_data <= w_in_head;
        end else r_dly <= r_dly - DW'(1);
        RD_PULSE: begin
          r_rd <= RD_DONE;
          r_in_count <= r_in_count + CNT_W'(1);
        end
        default: if (!dev_input_rdy) r_rd <= RD_IDLE;
      endcase
    end
  end
  assign w_pn_push = (r_pn == PN_IDLE) && dev_output_rdy && !w_out_full;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pn <= PN_IDLE;
      r_out_count <= '0;
    end else begin
      case (r_pn)
        PN_IDLE: if (w_pn_push) begin
          r_pn <= PN_ACK;
          r_out_count <= r_out_count + CNT_W'(1);
        end
        PN_ACK: r_pn <= PN_DONE;
        default: if (!dev_output_rdy) r_pn <= PN_IDLE;
      endcase
    end
  end
  assign dev_input_val = r_rd == RD_PULSE;
  assign dev_input_data = r_in_data;
  assign dev_output_ack = r_pn == PN_ACK;
  assign host_in_ready = !w_in_full;
  assign host_out_valid = !w_out_empty;
  assign in_count = r_in_count;
  assign out_count = r_out_count;
endmodule

// File: tb/tb_tape_device.sv
// tb_tape_device: directed and random stimulus against a queue-based model of the tape device
module tb_tape_device;
  localparam int IND = 8, OUTD = 2, RD = 4, CW = 2;
  logic clk = 0, reset = 1;
  logic host_in_valid = 0, tape_flush = 0, dev_input_rdy = 0, dev_output_rdy = 0, host_out_ready = 0;
  logic [4:0] host_in_data = 0, dev_output_data = 0;
  logic host_in_ready, dev_input_val, dev_output_ack, host_out_valid;
  logic [4:0] dev_input_data, host_out_data;
  logic [CW-1:0] in_count, out_count;
  int pass_n = 0, tot_n = 0;
  bit run_chk = 0;
  tape_device #(.IN_DEPTH(IND), .OUT_DEPTH(OUTD), .READ_DELAY(RD), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_in_data(host_in_data), .tape_flush(tape_flush), .dev_input_rdy(dev_input_rdy),
    .dev_input_val(dev_input_val), .dev_input_data(dev_input_data), .dev_output_rdy(dev_output_rdy),
    .dev_output_data(dev_output_data), .dev_output_ack(dev_output_ack), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready), .host_out_data(host_out_data), .in_count(in_count), .out_count(out_count)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    tot_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask
  // Model: tape and punch buffers as queues; a read request is remembered by the edge it was taken on
  logic [4:0] tq[$], oq[$];
  logic [4:0] e_data = 0;
  int m_in = 0, m_out = 0, req = -1, cyc = 0;
  bit served = 0, pulse_now = 0, ack_now = 0, p_served = 0;
  always @(posedge clk) begin
    bit in_push, in_pop, out_push, out_pop;
    cyc++;
    if (reset) begin
      tq.delete(); oq.delete();
      e_data = 0; m_in = 0; m_out = 0; req = -1;
      served = 0; pulse_now = 0; ack_now = 0; p_served = 0;
    end else begin
      in_push = host_in_valid && tq.size() < IND;
      out_pop = host_out_ready && oq.size() > 0;
      in_pop = pulse_now;
      out_push = 0;
      if (pulse_now) begin
        pulse_now = 0; served = 1; m_in = (m_in + 1) % (1 << CW);
      end else if (req >= 0) begin
        if (!dev_input_rdy || tape_flush) req = -1;
        else if (cyc == req + RD + 1) begin e_data = tq[0]; pulse_now = 1; req = -1; end
      end else if (served) begin
        if (!dev_input_rdy) served = 0;
      end else if (dev_input_rdy && tq.size() > 0 && !tape_flush) req = cyc;
      if (ack_now) begin
        ack_now = 0; p_served = 1;
      end else if (p_served) begin
        if (!dev_output_rdy) p_served = 0;
      end else if (dev_output_rdy && oq.size() < OUTD) begin
        out_push = 1; ack_now = 1; m_out = (m_out + 1) % (1 << CW);
      end
      if (in_pop) void'(tq.pop_front());
      if (tape_flush) tq.delete();
      else if (in_push) tq.push_back(host_in_data);
      if (out_pop) void'(oq.pop_front());
      if (out_push) oq.push_back(dev_output_data);
    end
  end
  always @(negedge clk) if (run_chk) begin
    chk("val", dev_input_val, pulse_now);
    chk("in_data", dev_input_data, e_data);
    chk("ack", dev_output_ack, ack_now);
    chk("in_ready", host_in_ready, tq.size() < IND);
    chk("out_valid", host_out_valid, oq.size() > 0);
    if (oq.size() > 0) chk("out_data", host_out_data, oq[0]);
    chk("in_count", in_count, m_in);
    chk("out_count", out_count, m_out);
  end
  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic push(logic [4:0] d);
    host_in_valid = 1; host_in_data = d;
    tick(1);
    host_in_valid = 0;
  endtask
  task automatic read_one(output int got, output int np, output int first);
    np = 0; first = -1; got = -1;
    dev_input_rdy = 1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (dev_input_val) begin np++; got = dev_input_data; if (first < 0) first = k; end
    end
    dev_input_rdy = 0;
    tick(2);
  endtask
  task automatic punch(logic [4:0] d, int n, output int na);
    na = 0; dev_output_data = d; dev_output_rdy = 1;
    for (int k = 0; k < n; k++) begin tick(1); if (dev_output_ack) na++; end
  endtask
  task automatic pop_out();
    host_out_ready = 1; tick(1); host_out_ready = 0;
  endtask
  initial begin
    int got, np, first, na;
    tick(1);
    run_chk = 1;
    tick(2);
    chk("rst_val", dev_input_val, 0); chk("rst_data", dev_input_data, 0);
    chk("rst_ack", dev_output_ack, 0); chk("rst_hov", host_out_valid, 0);
    chk("rst_hir", host_in_ready, 1); chk("rst_cnt", in_count + out_count, 0);
    reset = 0;
    tick(1);
    push(5'h11);
    read_one(got, np, first);
    chk("t1_first", first, 6); chk("t1_np", np, 1); chk("t1_data", got, 'h11);
    chk("t1_model_data", e_data, 'h11); chk("t1_cnt", in_count, 1);
    push(5'h03); push(5'h1F);
    read_one(got, np, first); chk("t2_a", got, 'h03); chk("t2_anp", np, 1);
    read_one(got, np, first); chk("t2_b", got, 'h1F); chk("t2_bnp", np, 1);
    read_one(got, np, first); chk("t2_empty_np", np, 0); chk("t2_cnt", in_count, 3);
    push(5'h07);
    np = 0;
    dev_input_rdy = 1;
    for (int k = 0; k < 3; k++) begin tick(1); np += int'(dev_input_val); end
    dev_input_rdy = 0;
    for (int k = 0; k < 3; k++) begin tick(1); np += int'(dev_input_val); end
    chk("t3_abort_np", np, 0);
    read_one(got, np, first); chk("t3_data", got, 'h07); chk("t3_wrap", in_count, 0);
    punch(5'h0A, 6, na); dev_output_rdy = 0; tick(2); chk("t4_ack1", na, 1);
    punch(5'h15, 6, na); dev_output_rdy = 0; tick(2); chk("t4_ack2", na, 1);
    punch(5'h1C, 6, na); chk("t4_stall", na, 0); chk("t4_head", host_out_data, 'h0A);
    pop_out();
    punch(5'h1C, 6, na); chk("t4_ack3", na, 1);
    dev_output_rdy = 0; tick(2);
    chk("t4_h2", host_out_data, 'h15); pop_out();
    chk("t4_h3", host_out_data, 'h1C); pop_out();
    chk("t4_empty", host_out_valid, 0); chk("t4_cnt", out_count, 3);
    for (int k = 1; k <= 5; k++) push(5'(k));
    tape_flush = 1; host_in_valid = 1; host_in_data = 5'h1E;
    tick(1);
    tape_flush = 0; host_in_valid = 0;
    chk("t5_hir", host_in_ready, 1); chk("t5_model_empty", tq.size(), 0);
    read_one(got, np, first); chk("t5_np", np, 0);
    push(5'h05);
    dev_input_rdy = 1; dev_output_rdy = 1; dev_output_data = 5'h09;
    tick(1); chk("t6_ack", dev_output_ack, 1);
    tick(1);
    reset = 1; tick(1);
    chk("t6_val", dev_input_val, 0); chk("t6_ack0", dev_output_ack, 0);
    chk("t6_hov", host_out_valid, 0); chk("t6_hir", host_in_ready, 1);
    chk("t6_cnt", in_count + out_count, 0); chk("t6_data", dev_input_data, 0);
    reset = 0; dev_input_rdy = 0; dev_output_rdy = 0;
    tick(2);
    for (int i = 0; i < 4000; i++) begin
      host_in_valid = $urandom_range(1, 0);
      host_in_data = 5'($urandom);
      tape_flush = $urandom_range(99, 0) < 3;
      if ($urandom_range(5, 0) == 0) dev_input_rdy = !dev_input_rdy;
      if ($urandom_range(4, 0) == 0) dev_output_rdy = !dev_output_rdy;
      dev_output_data = 5'($urandom);
      host_out_ready = $urandom_range(9, 0) < 4;
      reset = $urandom_range(999, 0) < 4;
      tick(1);
    end
    reset = 0; host_in_valid = 0; tape_flush = 0; dev_input_rdy = 0; dev_output_rdy = 0; host_out_ready = 0;
    tick(3);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
